stream_packer: RTL and testbench

STREAM_PACKER -- requirements
Module: stream_packer

---
 rtl/stream_packer_if.sv | 14 +
 rtl/stream_packer.sv | 152 +++++++++++++++
 tb/tb_stream_packer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_packer_if.sv
// AXI4-Stream bundle shared by the packer's input and output ports.
// The m modport drives a beat and the s modport accepts one.
interface AXI4S #(
  parameter int WIDTH = 512
);
  logic [WIDTH-1:0]   tdata;
  logic [WIDTH/8-1:0] tkeep;
  logic               tlast;
  logic               tvalid;
  logic               tready;

  modport m (output tdata, tkeep, tlast, tvalid, input  tready);
  modport s (input  tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/stream_packer.sv
// Packs sparse prefix-keep AXI4-Stream beats into full output beats.
// A partial beat can be emitted only as the tlast beat of a packet.
module stream_packer #(
  parameter int WIDTH       = 512,
  parameter int BYTES       = WIDTH / 8,
  parameter int COUNT_WIDTH = $clog2(BYTES) + 1
) (
  input logic aclk,
  input logic aresetn,
  AXI4S.s     i_data,
  AXI4S.m     o_data
);

  typedef enum logic {RUN, FLUSH} state_t;
  typedef logic [COUNT_WIDTH:0] total_t;  // one extra bit: r + n reaches 2*BYTES-1

  localparam total_t BYTES_T = total_t'(BYTES);

  function automatic logic [BYTES-1:0] keep_mask(input total_t cnt);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) m[i] = (total_t'(i) < cnt);
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] byte_expand(input logic [BYTES-1:0] m);
    logic [WIDTH-1:0] e;
    for (int i = 0; i < BYTES; i++) e[8*i +: 8] = {8{m[i]}};
    return e;
  endfunction

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0]       res_q, res_d;
  logic [WIDTH-1:0]       tdata_q, tdata_d;
  logic [BYTES-1:0]       tkeep_q, tkeep_d;
  logic                   tlast_q, tlast_d;
  logic                   tvalid_q, tvalid_d;

  logic [COUNT_WIDTH-1:0] n;
  total_t                 t;
  logic [2*WIDTH-1:0]     shifted;
  logic [WIDTH-1:0]       res_sel;
  logic [WIDTH-1:0]       merged;
  logic                   load_ok;
  logic                   in_ready;
  logic                   in_fire;

  assign load_ok  = !tvalid_q || o_data.tready;
  assign in_ready = aresetn && (state_q == RUN) && load_ok;
  assign in_fire  = i_data.tvalid && in_ready;

  assign i_data.tready = in_ready;
  assign o_data.tdata  = tdata_q;
  assign o_data.tkeep  = tkeep_q;
  assign o_data.tlast  = tlast_q;
  assign o_data.tvalid = tvalid_q;

  // Combined stream: residual bytes 0..r-1, then input bytes shifted up by r.
  // The upper half of the shifted word is what overflows into the next residual.
  always_comb begin
    n = '0;
    for (int i = 0; i < BYTES; i++) n = n + COUNT_WIDTH'(i_data.tkeep[i]);
    t       = total_t'(n) + total_t'(r_q);
    shifted = {{WIDTH{1'b0}}, i_data.tdata} << {r_q, 3'b000};
    res_sel = byte_expand(keep_mask(total_t'(r_q)));
    merged  = (res_q & res_sel) | (shifted[WIDTH-1:0] & ~res_sel);
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    r_d      = r_q;
    res_d    = res_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q && !o_data.tready;

    case (state_q)
      RUN: begin
        if (in_fire) begin
          if (t > BYTES_T) begin
            tdata_d  = merged;
            tkeep_d  = '1;
            tlast_d  = 1'b0;
            tvalid_d = 1'b1;
            res_d    = shifted[2*WIDTH-1:WIDTH];
            r_d      = COUNT_WIDTH'(t - BYTES_T);
            if (i_data.tlast) state_d = FLUSH;
          end else if (t == BYTES_T) begin
            tdata_d  = merged;
            tkeep_d  = '1;
            tlast_d  = i_data.tlast;
            tvalid_d = 1'b1;
            r_d      = '0;
          end else if (i_data.tlast) begin
            // An empty tlast beat with nothing buffered closes the packet silently.
            if (t != '0) begin
              tdata_d  = merged;
              tkeep_d  = keep_mask(t);
              tlast_d  = 1'b1;
              tvalid_d = 1'b1;
            end
            r_d = '0;
          end else begin
            res_d = merged;
            r_d   = COUNT_WIDTH'(t);
          end
        end
      end
      FLUSH: begin
        if (load_ok) begin
          tdata_d  = res_q;
          tkeep_d  = keep_mask(total_t'(r_q));
          tlast_d  = 1'b1;
          tvalid_d = 1'b1;
          r_d      = '0;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= RUN;
      r_q      <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  // NOTE: the residual data buffer is deliberately not reset; r=0 masks every
  // stale byte, so clearing it would only add reset fan-out.
  always_ff @(posedge aclk) begin
    res_q <= res_d;
  end

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer at WIDTH=512 (64 bytes per beat).
// Expected beats are assembled byte by byte from the stimulus pattern.
module tb_stream_packer;

  localparam int WIDTH = 512;
  localparam int BYTES = WIDTH / 8;

  logic aclk;
  logic aresetn;
  int   n_cmp;
  int   n_bad;

  AXI4S #(.WIDTH(WIDTH)) in_if ();
  AXI4S #(.WIDTH(WIDTH)) out_if ();

  stream_packer #(.WIDTH(WIDTH)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_data  (in_if),
    .o_data  (out_if)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Bytes 0..n-1 follow base+k; unused bytes carry filler that must never leak.
  function automatic logic [WIDTH-1:0] make_beat(input logic [7:0] base, input int nb);
    logic [WIDTH-1:0] d;
    for (int k = 0; k < BYTES; k++) d[8*k +: 8] = (k < nb) ? 8'(base + 8'(k)) : 8'hEE;
    return d;
  endfunction

  function automatic logic [BYTES-1:0] keep_of(input int nb);
    logic [BYTES-1:0] m;
    for (int k = 0; k < BYTES; k++) m[k] = (k < nb);
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] kept(input logic [WIDTH-1:0] d, input logic [BYTES-1:0] m);
    logic [WIDTH-1:0] r;
    for (int k = 0; k < BYTES; k++) r[8*k +: 8] = m[k] ? d[8*k +: 8] : 8'h00;
    return r;
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [BYTES-1:0] m, input logic l);
    in_if.tvalid = v;
    in_if.tdata  = d;
    in_if.tkeep  = m;
    in_if.tlast  = l;
  endtask

  logic [WIDTH-1:0] exp_d;
  logic [WIDTH-1:0] beat_a;
  logic [WIDTH-1:0] beat_b;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    aresetn = 1'b0;
    out_if.tready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();

    // Reset state
    check("rst_tvalid", WIDTH'(out_if.tvalid), '0);
    check("rst_tdata",  out_if.tdata, '0);
    check("rst_tkeep",  WIDTH'(out_if.tkeep), '0);
    check("rst_tlast",  WIDTH'(out_if.tlast), '0);
    check("rst_iready", WIDTH'(in_if.tready), '0);
    aresetn = 1'b1;
    #1;
    check("post_rst_iready", WIDTH'(in_if.tready), WIDTH'(1));

    // Scenario 1: 40B + 40B tlast -> full beat, then 16B flush beat
    drive(1'b1, make_beat(8'h00, 40), keep_of(40), 1'b0);
    tick();
    check("s1_no_out", WIDTH'(out_if.tvalid), '0);
    drive(1'b1, make_beat(8'h80, 40), keep_of(40), 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < BYTES; k++) exp_d[8*k +: 8] = (k < 40) ? 8'(k) : 8'(8'h80 + 8'(k - 40));
    check("s1_full_valid", WIDTH'(out_if.tvalid), WIDTH'(1));
    check("s1_full_keep",  WIDTH'(out_if.tkeep), WIDTH'({BYTES{1'b1}}));
    check("s1_full_last",  WIDTH'(out_if.tlast), '0);
    check("s1_full_data",  out_if.tdata, exp_d);
    check("s1_flush_iready", WIDTH'(in_if.tready), '0);
    tick();
    for (int k = 0; k < BYTES; k++) exp_d[8*k +: 8] = (k < 16) ? 8'(8'h98 + 8'(k)) : 8'h00;
    check("s1_tail_valid", WIDTH'(out_if.tvalid), WIDTH'(1));
    check("s1_tail_keep",  WIDTH'(out_if.tkeep), WIDTH'(64'hFFFF));
    check("s1_tail_last",  WIDTH'(out_if.tlast), WIDTH'(1));
    check("s1_tail_data",  kept(out_if.tdata, out_if.tkeep), exp_d);
    check("s1_run_iready", WIDTH'(in_if.tready), WIDTH'(1));
    tick();
    check("s1_idle", WIDTH'(out_if.tvalid), '0);

    // Empty tlast beat with nothing buffered produces nothing
    drive(1'b1, '0, '0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("empty_last_no_out", WIDTH'(out_if.tvalid), '0);

    // Scenario 2: single full tlast beat, latency 1
    beat_a = make_beat(8'h41, 64);
    drive(1'b1, beat_a, keep_of(64), 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("s2_valid", WIDTH'(out_if.tvalid), WIDTH'(1));
    check("s2_keep",  WIDTH'(out_if.tkeep), WIDTH'({BYTES{1'b1}}));
    check("s2_last",  WIDTH'(out_if.tlast), WIDTH'(1));
    check("s2_data",  out_if.tdata, beat_a);
    tick();
    check("s2_idle", WIDTH'(out_if.tvalid), '0);

    // Scenario 3: three 10B beats packed into one 30B tlast beat
    drive(1'b1, make_beat(8'h10, 10), keep_of(10), 1'b0);
    tick();
    check("s3_b1_no_out", WIDTH'(out_if.tvalid), '0);
    drive(1'b1, make_beat(8'h20, 10), keep_of(10), 1'b0);
    tick();
    check("s3_b2_no_out", WIDTH'(out_if.tvalid), '0);
    drive(1'b1, make_beat(8'h30, 10), keep_of(10), 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < BYTES; k++)
      exp_d[8*k +: 8] = (k < 10) ? 8'(8'h10 + 8'(k)) :
                        (k < 20) ? 8'(8'h20 + 8'(k - 10)) :
                        (k < 30) ? 8'(8'h30 + 8'(k - 20)) : 8'h00;
    check("s3_valid", WIDTH'(out_if.tvalid), WIDTH'(1));
    check("s3_keep",  WIDTH'(out_if.tkeep), WIDTH'(64'h3FFF_FFFF));
    check("s3_last",  WIDTH'(out_if.tlast), WIDTH'(1));
    check("s3_data",  kept(out_if.tdata, out_if.tkeep), exp_d);
    tick();

    // Scenario 4: backpressure for 5 cycles holds the output and stalls input
    out_if.tready = 1'b0;
    beat_a = make_beat(8'h50, 64);
    beat_b = make_beat(8'hA0, 64);
    drive(1'b1, beat_a, keep_of(64), 1'b1);
    tick();
    drive(1'b1, beat_b, keep_of(64), 1'b1);
    for (int c = 0; c < 5; c++) begin
      check("s4_hold_valid",  WIDTH'(out_if.tvalid), WIDTH'(1));
      check("s4_hold_data",   out_if.tdata, beat_a);
      check("s4_hold_keep",   WIDTH'(out_if.tkeep), WIDTH'({BYTES{1'b1}}));
      check("s4_hold_last",   WIDTH'(out_if.tlast), WIDTH'(1));
      check("s4_hold_iready", WIDTH'(in_if.tready), '0);
      tick();
    end
    out_if.tready = 1'b1;
    #1;
    check("s4_release_iready", WIDTH'(in_if.tready), WIDTH'(1));
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("s4_next_valid", WIDTH'(out_if.tvalid), WIDTH'(1));
    check("s4_next_data",  out_if.tdata, beat_b);
    tick();
    check("s4_idle", WIDTH'(out_if.tvalid), '0);

    // Scenario 5: reset during FLUSH drops the pending tail
    drive(1'b1, make_beat(8'h00, 40), keep_of(40), 1'b0);
    tick();
    drive(1'b1, make_beat(8'h80, 40), keep_of(40), 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("s5_full_before_rst", WIDTH'(out_if.tvalid), WIDTH'(1));
    aresetn = 1'b0;
    #1;
    check("s5_rst_iready", WIDTH'(in_if.tready), '0);
    tick();
    aresetn = 1'b1;
    check("s5_rst_valid", WIDTH'(out_if.tvalid), '0);
    check("s5_rst_keep",  WIDTH'(out_if.tkeep), '0);
    tick();
    check("s5_no_flush", WIDTH'(out_if.tvalid), '0);
    beat_a = make_beat(8'hC3, 64);
    drive(1'b1, beat_a, keep_of(64), 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("s5_new_valid", WIDTH'(out_if.tvalid), WIDTH'(1));
    check("s5_new_last",  WIDTH'(out_if.tlast), WIDTH'(1));
    check("s5_new_keep",  WIDTH'(out_if.tkeep), WIDTH'({BYTES{1'b1}}));
    check("s5_new_data",  out_if.tdata, beat_a);
    tick();
    check("s5_idle", WIDTH'(out_if.tvalid), '0);

    // Scenario 6: back-to-back full beats stream at one per cycle
    for (int i = 0; i < 4; i++) begin
      beat_a = make_beat(8'(8'h11 * (i + 1)), 64);
      drive(1'b1, beat_a, keep_of(64), i == 3);
      #1;
      check("s6_iready", WIDTH'(in_if.tready), WIDTH'(1));
      tick();
      check("s6_valid", WIDTH'(out_if.tvalid), WIDTH'(1));
      check("s6_data",  out_if.tdata, beat_a);
      check("s6_last",  WIDTH'(out_if.tlast), WIDTH'(i == 3));
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("s6_idle", WIDTH'(out_if.tvalid), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
